// File: rtl/prefetch_queue.sv
// Circular prefetch queue that presents its PEEK oldest entries in parallel.
// Each cycle it can consume up to PEEK entries and accept one new entry.
module prefetch_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int PEEK   = 3
) (
    input  logic                       clk,
    input  logic                       queue_reset,
    input  logic                       queue_flush,
    input  logic                       queue_push,
    input  logic [DATA_W-1:0]          queue_in,
    input  logic [1:0]                 queue_pull,
    output logic [PEEK*DATA_W-1:0]     queue_out,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic                       queue_full,
    output logic                       queue_empty,
    output logic                       push_ack,
    output logic                       pull_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic [CW-1:0]     pull_amt;
    logic              active;
    logic              pull_in_range;
    logic              pull_ok;
    logic              pull_bad;

    assign pull_amt      = CW'(queue_pull);
    assign active        = !queue_reset && !queue_flush;
    assign pull_in_range = (queue_pull != 2'd0) && (pull_amt <= CW'(PEEK)) && (pull_amt <= count);
    assign pull_ok       = active && pull_in_range;
    assign pull_bad      = active && (queue_pull != 2'd0) && !pull_in_range;

    // A full queue can still take a push when the same cycle frees space.
    assign push_ack = active && queue_push && ((count != CW'(DEPTH)) || pull_ok);

    always_comb begin
        next_count = count;
        if (pull_ok)
            next_count = next_count - pull_amt;
        if (push_ack)
            next_count = next_count + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (queue_reset || queue_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pull_err <= 1'b0;
        end else begin
            if (pull_ok)
                rd_ptr <= rd_ptr + AW'(queue_pull);
            if (push_ack)
                wr_ptr <= wr_ptr + AW'(1);
            count    <= next_count;
            pull_err <= pull_bad;
        end
    end

    // Storage is intentionally not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (push_ack)
            mem[wr_ptr] <= queue_in;
    end

    always_comb begin
        queue_out = '0;
        for (int k = 0; k < PEEK; k++) begin
            if (CW'(k) < count)
                queue_out[k*DATA_W +: DATA_W] = mem[rd_ptr + AW'(k)];
        end
    end

    assign queue_count = count;
    assign queue_full  = (count == CW'(DEPTH));
    assign queue_empty = (count == '0);

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning width of one queue entry in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, meaning entry count; legal values are powers of two, 4 or greater.
REQ-003 SHALL provide parameter PEEK, default 3, meaning the number of oldest entries presented in parallel; legal range is 1..3, and PEEK <= DEPTH.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port queue_reset, input, 1 bit, synchronous, active-high reset.
REQ-006 SHALL have port queue_flush, input, 1 bit, synchronous discard of all contents (branch taken / interrupt).
REQ-007 SHALL have port queue_push, input, 1 bit, write request for queue_in.
REQ-008 SHALL have port queue_in, input, DATA_W bits, entry to write.
REQ-009 SHALL have port queue_pull, input, 2 bits, number of entries to consume this cycle (0..PEEK).
REQ-010 SHALL have port queue_out, output, PEEK*DATA_W bits; slot k (bits k*DATA_W up) is the k-th oldest entry, slot 0 in the LSBs.
REQ-011 SHALL have port queue_count, output, clog2(DEPTH)+1 bits, current occupancy.
REQ-012 SHALL have port queue_full, output, 1 bit, high when count == DEPTH.
REQ-013 SHALL have port queue_empty, output, 1 bit, high when count == 0.
REQ-014 SHALL have port push_ack, output, 1 bit, high in any cycle where a push is accepted (combinational from current state and inputs).
REQ-015 SHALL have port pull_err, output, 1 bit, registered, one-cycle pulse after a rejected pull.

Function
REQ-016 SHALL store entries in a circular buffer with a read pointer, a write pointer, and a count; both pointers wrap modulo DEPTH.
REQ-017 SHALL accept a pull when 1 <= queue_pull <= min(count, PEEK): the read pointer advances by queue_pull and count decreases by queue_pull.
REQ-018 SHALL treat queue_pull > count, or queue_pull > PEEK, as a rejected pull: no state change from the pull, and pull_err = 1 in the next cycle only.
REQ-019 SHALL accept a push when queue_push = 1 and either (count < DEPTH) or (a pull is accepted in the same cycle); queue_in is written at the write pointer, which then advances by 1.
REQ-020 SHALL drop a push when full with no accepted pull: push_ack = 0 and no state change from the push.
REQ-021 SHALL, on a simultaneous accepted push and pull, set next count = count + 1 - queue_pull.
REQ-022 SHALL drive queue_out combinationally from storage at the read pointer; slot k reads entry (rd_ptr + k) mod DEPTH.
REQ-023 SHALL drive any queue_out slot with k >= count to all zeros.
REQ-024 SHALL not bypass: a pushed entry is visible on queue_out from the cycle after acceptance.
REQ-025 SHALL, when queue_flush = 1, set both pointers and count to 0 next cycle and ignore push/pull that cycle (push_ack = 0, pull_err not raised).
REQ-026 SHALL derive queue_full and queue_empty from the registered count with zero additional latency.
REQ-027 SHALL leave storage array contents undefined after reset/flush; only pointers, count and pull_err are reset.

Reset
REQ-028 SHALL, when queue_reset = 1 at a clock edge, set rd_ptr = 0, wr_ptr = 0, count = 0, pull_err = 0 regardless of other inputs.
REQ-029 SHALL give queue_reset priority over queue_flush, queue_push and queue_pull.
REQ-030 SHALL present the following after reset: queue_count = 0, queue_empty = 1, queue_full = 0, queue_out = 0, push_ack = 0 while queue_reset is high.
REQ-031 SHALL discard all contents when reset is asserted mid-operation; the first post-reset push lands at index 0.

Verification
REQ-032 SHALL cover fill/drain (defaults): push 0x10..0x1F over 16 cycles -> queue_full = 1, count = 16, queue_out = 0x12_11_10; push 0x20 -> push_ack = 0, count stays 16.
REQ-033 SHALL cover a multi-entry pull: contents 0xA9,0x05,0x8D,0x00 and queue_pull = 2 -> next cycle count = 2, queue_out = 0x00_00_8D... slot0 = 0x8D, slot1 = 0x00, slot2 = 0x00 (zero-filled).
REQ-034 SHALL cover a pull error: count = 1, queue_pull = 3 -> count remains 1, pull_err = 1 for exactly one cycle.
REQ-035 SHALL cover simultaneous push and pull while full: count = 16, push 0x55 with queue_pull = 1 -> push_ack = 1, count = 16, and 0x55 is written at the wrapped index (rd_ptr - 1) mod 16.
REQ-036 SHALL cover wrap-around: pointers at 14, push 4 entries, pull 3 -> slot0 equals the entry stored at index 1, count = previous count + 1.
REQ-037 SHALL cover flush versus reset priority: assert queue_flush and queue_push together -> count = 0, push_ack = 0; assert queue_reset and queue_flush with pull = 3 on count = 0 -> pull_err = 0 next cycle.
